// File: rtl/cmp_sort_ctrl.sv
// Frame buffer with a bubble-sort scheduler: loads N values, sorts them ascending with one
// shared subtract-style compare per clock, then streams the sorted frame out.
module cmp_sort_ctrl #(
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic          busy,
  output logic [CW-1:0] cmp_count
);

  localparam int unsigned PW = (N > 2) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LastIdx  = PW'(N - 1);
  localparam logic [PW-1:0] LastPass = PW'(N - 2);

  typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

  state_e        state;
  logic [PW-1:0] wr_ptr, rd_ptr, j, pass;
  logic          swapped;
  logic [W-1:0]  mem [N];

  logic [PW-1:0] j_nx, rd_nx, j_last;
  logic [W-1:0]  cmp_a, cmp_b, first_val;
  logic [W:0]    diff;
  logic          gt, pass_end, swapped_now;

  always_comb begin
    j_nx        = j + 1'b1;
    rd_nx       = rd_ptr + 1'b1;
    j_last      = LastPass - pass;
    cmp_a       = mem[j];
    cmp_b       = mem[j_nx];
    // A - B as A + ~B + 1: carry-out means A >= B, non-zero difference excludes equality.
    diff        = {1'b0, cmp_a} + {1'b0, ~cmp_b} + (W+1)'(1);
    gt          = diff[W] & (|diff[W-1:0]);
    pass_end    = (j == j_last);
    swapped_now = swapped | gt;
    // Entry 0 as it will look after this cycle's compare, for the first drain beat.
    first_val   = (j == '0 && gt) ? cmp_b : mem[0];
  end

  assign in_ready = (state == StLoad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StLoad;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      j         <= '0;
      pass      <= '0;
      swapped   <= 1'b0;
      cmp_count <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      unique case (state)
        StLoad: begin
          if (in_valid) begin
            mem[wr_ptr] <= in_data;
            if (wr_ptr == LastIdx) begin
              state     <= StSort;
              wr_ptr    <= '0;
              j         <= '0;
              pass      <= '0;
              swapped   <= 1'b0;
              cmp_count <= '0;
              busy      <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        StSort: begin
          if (cmp_count != '1) cmp_count <= cmp_count + 1'b1;
          if (gt) begin
            mem[j]    <= cmp_b;
            mem[j_nx] <= cmp_a;
          end
          if (pass_end) begin
            if (!swapped_now || pass == LastPass) begin
              state     <= StDrain;
              rd_ptr    <= '0;
              busy      <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= first_val;
              out_last  <= 1'b0;
            end else begin
              pass    <= pass + 1'b1;
              j       <= '0;
              swapped <= 1'b0;
            end
          end else begin
            j       <= j_nx;
            swapped <= swapped_now;
          end
        end
        StDrain: begin
          if (out_ready) begin
            if (rd_ptr == LastIdx) begin
              state     <= StLoad;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              rd_ptr   <= rd_nx;
              out_data <= mem[rd_nx];
              out_last <= (rd_nx == LastIdx);
            end
          end
        end
        default: state <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Self-checking bench for cmp_sort_ctrl: directed and random frames against a sorting model.
module tb_cmp_sort_ctrl;

  typedef logic [3:0] frame_t [8];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;
  logic [7:0] cmp_count;

  int n_cmp  = 0;
  int n_fail = 0;

  cmp_sort_ctrl #(.N(8), .W(4), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .cmp_count (cmp_count)
  );

  always #5 clk = ~clk;

  // Bubble sort with early exit, counting compares: pass p examines 7-p adjacent pairs.
  function automatic int model_compares(input frame_t v);
    int a[8];
    int cnt = 0;
    for (int i = 0; i < 8; i++) a[i] = int'(v[i]);
    for (int p = 0; p < 7; p++) begin
      bit sw = 1'b0;
      for (int k = 0; k < 7 - p; k++) begin
        cnt++;
        if (a[k] > a[k+1]) begin
          int t = a[k];
          a[k] = a[k+1];
          a[k+1] = t;
          sw = 1'b1;
        end
      end
      if (!sw) break;
    end
    return cnt;
  endfunction

  task automatic load_frame(input frame_t v, input bit hold);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ready beat %0d: got %b want 1", i, in_ready);
      end
      in_valid = 1'b1;
      in_data  = v[i];
    end
    @(negedge clk);
    in_valid = hold;
    in_data  = 4'($urandom);
  endtask

  // Sorts one frame end to end; rmode 0: always ready, 1: 1,0,0 pattern, 2: random.
  task automatic test_frame(input frame_t v, input int rmode, input bit hold, input string tag);
    logic [3:0] exp_q[$];
    int exp_cmp, cycles, beats, guard, k;
    bit stalled;
    logic [3:0] held;
    for (int i = 0; i < 8; i++) exp_q.push_back(v[i]);
    exp_q.sort();
    exp_cmp = model_compares(v);
    load_frame(v, hold);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s sort_handshake: in_ready=%b out_valid=%b want 0/0", tag, in_ready,
                 out_valid);
      end
      if (hold) in_data = 4'($urandom);
      @(negedge clk);
    end
    n_cmp++;
    if (cycles != exp_cmp) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, cycles, exp_cmp);
    end
    beats = 0; guard = 0; k = 0; stalled = 1'b0; held = '0;
    while (beats < 8 && guard < 500) begin
      guard++;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || (stalled && out_data !== held)) begin
        n_fail++;
        $display("FAIL %s drain_hold: valid=%b in_ready=%b data=%0d held=%0d", tag, out_valid,
                 in_ready, out_data, held);
      end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = 1'($urandom);
      endcase
      k++;
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (out_data !== exp_q[beats] || out_last !== (beats == 7) || cmp_count !== 8'(exp_cmp))
        begin
          n_fail++;
          $display("FAIL %s beat %0d: data=%0d last=%b cmp=%0d want %0d/%b/%0d", tag, beats,
                   out_data, out_last, cmp_count, exp_q[beats], beats == 7, exp_cmp);
        end
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = out_data;
      end
      if (hold) in_data = 4'($urandom);
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_cmp++;
    if (beats != 8 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        cmp_count !== 8'(exp_cmp)) begin
      n_fail++;
      $display("FAIL %s frame_end: beats=%0d in_ready=%b out_valid=%b busy=%b cmp=%0d", tag,
               beats, in_ready, out_valid, busy, cmp_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'd9;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
        cmp_count !== 8'd0 || out_data !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b vld=%b last=%b busy=%b cmp=%0d data=%0d", in_ready,
               out_valid, out_last, busy, cmp_count, out_data);
    end
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_sort();
    frame_t f, g;
    f = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
    g = '{4'd3, 4'd1, 4'd2, 4'd0, 4'd7, 4'd5, 4'd6, 4'd4};
    load_frame(f, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || cmp_count !== 8'd10) begin
      n_fail++;
      $display("FAIL midsort_count: busy=%b cmp=%0d want 1/10", busy, cmp_count);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || cmp_count !== 8'd0 ||
        out_last !== 1'b0 || out_data !== 4'd0) begin
      n_fail++;
      $display("FAIL midsort_reset: rdy=%b vld=%b busy=%b cmp=%0d last=%b data=%0d", in_ready,
               out_valid, busy, cmp_count, out_last, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    test_frame(g, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random(input int frames);
    frame_t f;
    for (int n = 0; n < frames; n++) begin
      for (int i = 0; i < 8; i++) f[i] = 4'($urandom);
      test_frame(f, 2, 1'($urandom), "random");
    end
  endtask

  initial begin
    frame_t f;
    test_reset();
    f = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
    test_frame(f, 0, 1'b0, "reverse");
    f = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    test_frame(f, 0, 1'b0, "sorted");
    f = '{4'd7, 4'd8, 4'd0, 4'd15, 4'd15, 4'd0, 4'd8, 4'd7};
    test_frame(f, 0, 1'b0, "signed_trap");
    f = '{4'd9, 4'd2, 4'd12, 4'd5, 4'd0, 4'd14, 4'd3, 4'd8};
    test_frame(f, 1, 1'b0, "backpressure");
    f = '{4'd4, 4'd4, 4'd1, 4'd10, 4'd6, 4'd13, 4'd2, 4'd11};
    test_frame(f, 0, 1'b1, "hold_valid");
    test_reset_mid_sort();
    test_random(12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
